sram_req_ctrl: RTL
==================

// Module: sram_req_ctrl
// PURPOSE
// Downstream stage of the AXI4 slave front-end. Consumes its simple request/response
//   channel (one beat per request) and drives a single-port synchronous SRAM.
// Returns read data or write acknowledge with an error flag for out-of-window addresses.
// Sits between the AXI slave adapter and the on-chip RAM macro in each memory-mapped slot.
// PARAMETERS
// abits       12  SRAM word-address width; depth = 2**abits words of CFG_SYSBUS_DATA_BITS
// log2_window 20  decoded window size in bytes (log2); offsets >= 2**(abits+3) inside it -> error
// rd_latency  1   SRAM read latency in cycles, legal 1..3
// PORTS
// i_clk         in   1                     clock, all logic on rising edge
// i_rst         in   1                     reset, synchronous, active-high
// i_req_valid   in   1                     request valid
// o_req_ready   out  1                     request accepted when valid&ready
// i_req_addr    in   CFG_SYSBUS_ADDR_BITS  byte address
// i_req_write   in   1                     1=write, 0=read
// i_req_wdata   in   CFG_SYSBUS_DATA_BITS  write data
// i_req_wstrb   in   CFG_SYSBUS_DATA_BYTES byte strobes
// i_req_last    in   1                     last beat of burst, echoed as o_resp_last
// o_resp_valid  out  1                     response valid
// i_resp_ready  in   1                     response consumed when valid&ready
// o_resp_rdata  out  CFG_SYSBUS_DATA_BITS  read data (0 for writes and errors)
// o_resp_last   out  1                     copy of accepted i_req_last
// o_resp_err    out  1                     address outside implemented SRAM
// o_mem_cs      out  1                     SRAM chip select, one-cycle pulse
// o_mem_we      out  1                     SRAM write enable (valid with cs)
// o_mem_addr    out  abits                 word address = i_req_addr[abits+2:3]
// o_mem_wstrb   out  CFG_SYSBUS_DATA_BYTES byte write enables
// o_mem_wdata   out  CFG_SYSBUS_DATA_BITS  write data
// i_mem_rdata   in   CFG_SYSBUS_DATA_BITS  read data, valid rd_latency cycles after cs
// BEHAVIOUR
// - Reset (i_rst=1 at edge): state=Idle, all outputs 0 except o_req_ready=1 after reset
//   deasserts; any in-flight SRAM read or pending response is dropped, not replayed.
// - States: Idle, Access, RdWait, Resp.
// - o_req_ready = (state==Idle) | (state==Resp & i_resp_ready). Single outstanding request.
// - Accept: capture addr/write/wstrb/last; err = |i_req_addr[log2_window-1:abits+3].
//   err=0 -> Access; err=1 -> Resp next cycle with o_resp_err=1, rdata=0, no SRAM access.
// - Access (1 cycle): o_mem_cs=1, o_mem_we=write, addr/wstrb/wdata from captured request.
//   write -> Resp (ack one cycle after cs); read -> RdWait, counter=rd_latency-1.
// - RdWait: counter decrements each cycle; when counter==0, sample i_mem_rdata into
//   o_resp_rdata -> Resp. rd_latency=1: sample in first RdWait cycle (cs at T, data at T+1).
// - Resp: o_resp_valid=1; outputs stable while i_resp_ready=0. On valid&ready: if
//   i_req_valid also 1, accept new request same cycle (back-to-back), else -> Idle.
// - Latency req-accept to o_resp_valid: write 2, read 2+rd_latency, error 1 cycles.
// - wstrb=0 write: SRAM cycle still issued with wstrb=0, normal ack, err=0.
// - o_mem_cs is never asserted outside Access; o_mem_* other than cs hold last value.
// - Address bits [2:0] ignored (bus-aligned); bits >= log2_window ignored (decoded upstream).
// TESTING
// - Reset: hold i_rst 3 cycles mid-read (RdWait) -> o_resp_valid=0, o_mem_cs=0, Idle,
//   o_req_ready=1 first cycle after release.
// - Write 0x...0010, wdata=0x1122334455667788, wstrb=0x0F -> cs/we at T+1, mem_addr=2,
//   o_resp_valid T+2, err=0; read back (lat=1) -> rdata low 32b =0x55667788.
// - Read with rd_latency=3 -> cs at T+1, o_resp_valid at T+5, rdata equals SRAM model.
// - Addr 0x8000 (abits=12) -> no cs, o_resp_valid T+1, err=1, rdata=0.
// - i_resp_ready=0 for 4 cycles -> response held stable, o_req_ready=0; then back-to-back
//   accept on release, next cs one cycle later.
// - Burst of 4 reads, last only on beat 4 -> o_resp_last=1 only on 4th response.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// Request/response to single-port synchronous SRAM bridge for one memory-mapped slot.
// One outstanding request; out-of-window offsets answer with an error and never touch the SRAM.
module sram_req_ctrl #(
  parameter int abits       = 12,
  parameter int log2_window = 20,
  parameter int rd_latency  = 1,
  parameter int addr_bits   = 32,
  parameter int data_bits   = 64,
  parameter int data_bytes  = data_bits / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [addr_bits-1:0]  i_req_addr,
  input  logic                  i_req_write,
  input  logic [data_bits-1:0]  i_req_wdata,
  input  logic [data_bytes-1:0] i_req_wstrb,
  input  logic                  i_req_last,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [data_bits-1:0]  o_resp_rdata,
  output logic                  o_resp_last,
  output logic                  o_resp_err,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [abits-1:0]      o_mem_addr,
  output logic [data_bytes-1:0] o_mem_wstrb,
  output logic [data_bits-1:0]  o_mem_wdata,
  input  logic [data_bits-1:0]  i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_t;

  localparam logic [1:0] lat_m1 = 2'(rd_latency - 1);

  state_t     state;
  logic [1:0] rd_cnt;
  logic       accept;
  logic       req_err;
  logic       unused_addr_bits;

  generate
    if (log2_window > abits + 3) begin : g_err_decode
      assign req_err = |i_req_addr[log2_window-1:abits+3];
    end else begin : g_no_err_decode
      assign req_err = 1'b0;
    end
  endgenerate

  // Byte-lane bits and bits above the window are decoded elsewhere.
  assign unused_addr_bits = ^{i_req_addr[addr_bits-1:log2_window], i_req_addr[2:0]};

  // Held low during reset so the upstream adapter cannot hand over a beat that would be lost.
  assign o_req_ready  = ~i_rst & ((state == IDLE) | ((state == RESP) & i_resp_ready));
  assign accept       = i_req_valid & o_req_ready;
  assign o_resp_valid = (state == RESP);

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values
    // and the accept branch below can override the state-machine defaults cleanly.
    if (i_rst) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      o_resp_rdata <= '0;
      o_resp_last  <= 1'b0;
      o_resp_err   <= 1'b0;
      o_mem_cs     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wstrb  <= '0;
      o_mem_wdata  <= '0;
    end else begin
      o_mem_cs <= 1'b0;

      case (state)
        IDLE: ;
        ACCESS: begin
          if (o_mem_we) begin
            state <= RESP;
          end else begin
            state  <= RD_WAIT;
            rd_cnt <= lat_m1;
          end
        end
        RD_WAIT: begin
          if (rd_cnt == 2'd0) begin
            o_resp_rdata <= i_mem_rdata;
            state        <= RESP;
          end else begin
            rd_cnt <= rd_cnt - 2'd1;
          end
        end
        RESP: begin
          if (i_resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new beat (from Idle or back-to-back out of Resp) takes priority over the defaults above.
      if (accept) begin
        o_resp_last  <= i_req_last;
        o_resp_err   <= req_err;
        o_resp_rdata <= '0;
        if (req_err) begin
          state <= RESP;
        end else begin
          state       <= ACCESS;
          o_mem_cs    <= 1'b1;
          o_mem_we    <= i_req_write;
          o_mem_addr  <= i_req_addr[abits+2:3];
          o_mem_wstrb <= i_req_wstrb;
          o_mem_wdata <= i_req_wdata;
        end
      end
    end
  end

endmodule
